// File: rtl/qeciphy_link_ctrl_ml.sv
// Multi-lane link bring-up controller: sequences bonded SERDES lanes from reset to READY,
// with per-phase timeouts, bounded retraining and a sticky fatal state.
module qeciphy_link_ctrl_ml #(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRAIN_HOLD   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reset_done_i,
  input  logic [NUM_LANES-1:0] lane_aligned_i,
  input  logic [NUM_LANES-1:0] lane_rx_ready_i,
  input  logic                 remote_rx_ready_i,
  input  logic                 fault_fatal_i,
  output logic                 link_ready_o,
  output logic                 fault_fatal_o,
  output logic [3:0]           status_o,
  output logic                 tx_link_enable_o,
  output logic                 rx_enable_o,
  output logic                 tx_data_enable_o,
  output logic [3:0]           retry_count_o,
  output logic                 timeout_o
);

  // Status codes reported on status_o
  localparam logic [3:0] STAT_RESET          = 4'd0;
  localparam logic [3:0] STAT_WAIT_FOR_RESET = 4'd1;
  localparam logic [3:0] STAT_LINK_TRAINING  = 4'd2;
  localparam logic [3:0] STAT_RX_LOCKED      = 4'd3;
  localparam logic [3:0] STAT_LINK_READY     = 4'd4;
  localparam logic [3:0] STAT_FAULT_FATAL    = 4'd5;

  // One counter serves both the wait-state timeouts and the retrain hold
  localparam int CNT_MAX = (TIMEOUT_CYCLES > RETRAIN_HOLD) ? TIMEOUT_CYCLES : RETRAIN_HOLD;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RETRAIN_HOLD - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_RESET           = 4'd0,
    S_WAIT_RESET_DONE = 4'd1,
    S_TX_LINK_ENABLE  = 4'd2,
    S_WAIT_ALIGN      = 4'd3,
    S_RX_ENABLE       = 4'd4,
    S_WAIT_RX_LOCKED  = 4'd5,
    S_WAIT_REMOTE     = 4'd6,
    S_TX_DATA_ENABLE  = 4'd7,
    S_READY           = 4'd8,
    S_RETRAIN         = 4'd9,
    S_FAULT_FATAL     = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             timeout_q, timeout_d;

  logic all_aligned, all_locked, expired, retry_event, counting;

  always_comb begin
    all_aligned = &lane_aligned_i;
    all_locked  = &lane_rx_ready_i;
    expired     = (cnt_q == TMO_LAST);
    state_d     = state_q;
    retry_d     = retry_q;
    timeout_d   = 1'b0;
    retry_event = 1'b0;

    case (state_q)
      S_RESET:           state_d = S_WAIT_RESET_DONE;
      S_WAIT_RESET_DONE: if (reset_done_i) state_d = S_TX_LINK_ENABLE;
      S_TX_LINK_ENABLE:  state_d = S_WAIT_ALIGN;
      S_WAIT_ALIGN: begin
        if (all_aligned) begin
          state_d = S_RX_ENABLE;
        end else if (expired) begin
          timeout_d   = 1'b1;
          retry_event = 1'b1;
        end
      end
      S_RX_ENABLE:       state_d = S_WAIT_RX_LOCKED;
      S_WAIT_RX_LOCKED: begin
        if (all_locked) begin
          state_d = S_WAIT_REMOTE;
        end else if (expired) begin
          timeout_d   = 1'b1;
          retry_event = 1'b1;
        end
      end
      S_WAIT_REMOTE: begin
        if (remote_rx_ready_i && all_locked) begin
          state_d = S_TX_DATA_ENABLE;
        end else if (expired) begin
          timeout_d   = 1'b1;
          retry_event = 1'b1;
        end
      end
      S_TX_DATA_ENABLE: begin
        state_d = S_READY;
        retry_d = 4'd0;
      end
      S_READY:           if (!(all_aligned && all_locked)) retry_event = 1'b1;
      S_RETRAIN:         if (cnt_q == HOLD_LAST) state_d = S_TX_LINK_ENABLE;
      S_FAULT_FATAL:     state_d = S_FAULT_FATAL;
      default:           state_d = S_RESET;
    endcase

    // Retry budget exhausted: the event becomes fatal and the count is left as-is
    if (retry_event) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 4'd1;
        state_d = S_RETRAIN;
      end else begin
        state_d = S_FAULT_FATAL;
      end
    end

    // External fatal overrides whatever the FSM decided this cycle
    if (fault_fatal_i) begin
      state_d   = S_FAULT_FATAL;
      retry_d   = retry_q;
      timeout_d = 1'b0;
    end

    counting = (state_q == S_WAIT_ALIGN) || (state_q == S_WAIT_RX_LOCKED) ||
               (state_q == S_WAIT_REMOTE) || (state_q == S_RETRAIN);
    if (state_d != state_q || !counting) cnt_d = '0;
    else                                 cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    link_ready_o     = 1'b0;
    fault_fatal_o    = 1'b0;
    tx_link_enable_o = 1'b0;
    rx_enable_o      = 1'b0;
    tx_data_enable_o = 1'b0;
    status_o         = STAT_RESET;
    case (state_q)
      S_WAIT_RESET_DONE: status_o = STAT_WAIT_FOR_RESET;
      S_TX_LINK_ENABLE, S_WAIT_ALIGN: begin
        tx_link_enable_o = 1'b1;
        status_o         = STAT_LINK_TRAINING;
      end
      S_RX_ENABLE, S_WAIT_RX_LOCKED: begin
        tx_link_enable_o = 1'b1;
        rx_enable_o      = 1'b1;
        status_o         = STAT_LINK_TRAINING;
      end
      S_WAIT_REMOTE: begin
        tx_link_enable_o = 1'b1;
        rx_enable_o      = 1'b1;
        status_o         = STAT_RX_LOCKED;
      end
      S_TX_DATA_ENABLE: begin
        tx_link_enable_o = 1'b1;
        rx_enable_o      = 1'b1;
        tx_data_enable_o = 1'b1;
        status_o         = STAT_RX_LOCKED;
      end
      S_READY: begin
        tx_link_enable_o = 1'b1;
        rx_enable_o      = 1'b1;
        tx_data_enable_o = 1'b1;
        link_ready_o     = 1'b1;
        status_o         = STAT_LINK_READY;
      end
      S_RETRAIN:         status_o = STAT_LINK_TRAINING;
      S_FAULT_FATAL: begin
        fault_fatal_o = 1'b1;
        status_o      = STAT_FAULT_FATAL;
      end
      default:           status_o = STAT_RESET;
    endcase
  end

  assign retry_count_o = retry_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_qeciphy_link_ctrl_ml.sv
// Directed bench for qeciphy_link_ctrl_ml: bring-up, timeouts, retrain, exhaustion, race and priority.
module tb_qeciphy_link_ctrl_ml;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          reset_done;
  logic [NL-1:0] lane_aligned;
  logic [NL-1:0] lane_rx_ready;
  logic          remote_rx_ready;
  logic          fault_in;
  logic          link_ready;
  logic          fault_out;
  logic [3:0]    status;
  logic          tx_link_en;
  logic          rx_en;
  logic          tx_data_en;
  logic [3:0]    retry_count;
  logic          timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qeciphy_link_ctrl_ml #(
    .NUM_LANES(NL), .TIMEOUT_CYCLES(16), .MAX_RETRIES(3), .RETRAIN_HOLD(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .reset_done_i(reset_done),
    .lane_aligned_i(lane_aligned), .lane_rx_ready_i(lane_rx_ready),
    .remote_rx_ready_i(remote_rx_ready), .fault_fatal_i(fault_in),
    .link_ready_o(link_ready), .fault_fatal_o(fault_out), .status_o(status),
    .tx_link_enable_o(tx_link_en), .rx_enable_o(rx_en), .tx_data_enable_o(tx_data_en),
    .retry_count_o(retry_count), .timeout_o(timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Everything an idle/reset block must show: all outputs zero
  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {link_ready, fault_out, tx_link_en, rx_en, tx_data_en, timeout}, 0);
    chk({tag, ".status"}, status, 4'd0);
    chk({tag, ".retry"}, retry_count, 4'd0);
  endtask

  initial begin
    rst = 1'b1; reset_done = 1'b0; lane_aligned = '0; lane_rx_ready = '0;
    remote_rx_ready = 1'b0; fault_in = 1'b0;
    step(); step();
    chk_all_zero("reset");

    // Happy path
    rst = 1'b0;
    step();
    chk("wrd.status", status, 4'd1);
    lane_aligned = 4'hF; lane_rx_ready = 4'hF; remote_rx_ready = 1'b1;
    step();
    chk("wrd.hold", status, 4'd1);
    reset_done = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("happy.ready%0d", i), link_ready, (i == 7));
      if (i == 1) chk("happy.txlink", {tx_link_en, rx_en, tx_data_en}, 3'b100);
      if (i == 3) chk("happy.rxen", {tx_link_en, rx_en, tx_data_en}, 3'b110);
      if (i == 5) chk("happy.remote_status", status, 4'd3);
    end
    chk("happy.status", status, 4'd4);
    chk("happy.enables", {tx_link_en, rx_en, tx_data_en}, 3'b111);
    chk("happy.retry", retry_count, 4'd0);

    // Link loss: one-cycle drop of lane 0 lock
    lane_rx_ready = 4'hE;
    step();
    lane_rx_ready = 4'hF;
    chk("loss.txdata", tx_data_en, 1'b0);
    chk("loss.retry", retry_count, 4'd1);
    chk("loss.status", status, 4'd2);
    chk("loss.timeout", timeout, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("loss.hold%0d", i), {tx_link_en, rx_en, tx_data_en}, 3'b000);
    end
    step();
    chk("loss.txlink_back", tx_link_en, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("loss.ready", link_ready, 1'b1);
    chk("loss.retry_clr", retry_count, 4'd0);

    // Partial align: lane 2 never aligns
    rst = 1'b1; step(); rst = 1'b0;
    lane_aligned = 4'hB;
    step(); step(); step();
    chk("palign.entry_status", status, 4'd2);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("palign.wait%0d", i), timeout, 1'b0);
    end
    step();
    chk("palign.timeout", timeout, 1'b1);
    chk("palign.retry", retry_count, 4'd1);
    chk("palign.enables", {tx_link_en, rx_en, tx_data_en}, 3'b000);
    step();
    chk("palign.pulse_end", timeout, 1'b0);
    step();
    // Reset mid-RETRAIN
    rst = 1'b1;
    step();
    chk_all_zero("rst_retrain");

    // Race: alignment arrives on the expiry cycle
    rst = 1'b0;
    step(); step(); step();
    for (int i = 1; i <= 15; i++) step();
    lane_aligned = 4'hF;
    step();
    chk("race.rxen", rx_en, 1'b1);
    chk("race.timeout", timeout, 1'b0);
    chk("race.retry", retry_count, 4'd0);
    for (int i = 0; i < 4; i++) step();
    chk("race.ready", link_ready, 1'b1);

    // External fatal in READY, sticky until reset
    fault_in = 1'b1;
    step();
    fault_in = 1'b0;
    chk("xfatal.fault", fault_out, 1'b1);
    chk("xfatal.status", status, 4'd5);
    chk("xfatal.ready", link_ready, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("xfatal.sticky", fault_out, 1'b1);
    rst = 1'b1;
    step();
    chk_all_zero("rst_fatal");

    // Exhaustion: remote never ready
    remote_rx_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("exh.wait_remote", status, 4'd3);
    for (int r = 1; r <= 3; r++) begin
      for (int i = 0; i < 16; i++) step();
      chk($sformatf("exh.timeout%0d", r), timeout, 1'b1);
      chk($sformatf("exh.retry%0d", r), retry_count, 4'(r));
      chk($sformatf("exh.retrain%0d", r), status, 4'd2);
      for (int i = 0; i < 20; i++) step();
      chk($sformatf("exh.back%0d", r), status, 4'd3);
    end
    for (int i = 0; i < 16; i++) step();
    chk("exh.fatal", fault_out, 1'b1);
    chk("exh.status", status, 4'd5);
    chk("exh.retry_final", retry_count, 4'd3);
    chk("exh.timeout_final", timeout, 1'b1);
    remote_rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("exh.sticky", fault_out, 1'b1);
    chk("exh.enables", {tx_link_en, rx_en, tx_data_en, timeout}, 4'b0000);
    rst = 1'b1;
    step();
    chk_all_zero("rst_exh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
